fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Front-end fetch stage that sits directly upstream of the IFU and feeds the decode stage. It owns the PC and drives the IFU read command. It buffers fetched instructions, tagged with their PC, in a 2-entry queue towards decode. It also handles control-flow redirects and records IFU alignment and bus faults in program order.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
ADDR_WIDTH, 32, PC and fetch address width (`CPU_ADDR_WIDTH)
INSTR_WIDTH, 32, instruction width (`CPU_INSTR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  out  ADDR_WIDTH  fetch address to IFU
rd_cmd  out  1  fetch request to IFU
instr_dat  in  INSTR_WIDTH  instruction from IFU, valid when rd_cmd && !busy
busy  in  1  IFU busy; fetch completes in the cycle busy is low while rd_cmd is high
err_align  in  1  IFU alignment fault (combinational on rd_cmd/addr)
err_bus  in  1  IFU bus fault
redirect  in  1  control-flow change request
redirect_pc  in  ADDR_WIDTH  redirect target
o_valid  out  1  head entry valid to decode
o_instr  out  INSTR_WIDTH  head instruction (0 when the entry is a fault)
o_pc  out  ADDR_WIDTH  PC of head entry
o_exc  out  2  head exception code: NONE=0, ALIGN=1, BUS=2
i_ready  in  1  decode accepts head entry (pop when o_valid && i_ready)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: pc=RESET_ADDR, state=RUN, queue count=0, inflight=0, discard=0, o_valid=0, o_instr=0, o_pc=0, o_exc=0.
- While rst=1, rd_cmd is forced to 0.
- States:
  - RUN: issue fetches.
  - HALT: a fault has been queued; no issue until redirect.
- rd_cmd = inflight | (state==RUN && count<2 && !redirect). It is combinational so that a zero-wait IFU completes in the same cycle.
- addr = pc.
- Once asserted, rd_cmd and addr are held stable until completion (busy=0). inflight is set when rd_cmd && busy.
- Completion (rd_cmd && !busy):
  - If there is no fault and no discard: push {pc, instr_dat, NONE}; pc <= pc+4, wrapping modulo 2^ADDR_WIDTH.
  - If err_align or err_bus: push {pc, 0, ALIGN|BUS}, with ALIGN taking priority; pc unchanged; state <= HALT.
- Queue:
  - 2-entry FIFO; push and pop in the same cycle are allowed.
  - Push is always guaranteed space, because an issue requires count<2 and only the single outstanding fetch pushes.
  - Outputs come from the head register, so there is one cycle of latency from completion to o_valid.
- Redirect when no fetch is inflight:
  - Flush the queue (count<=0, o_valid=0 next cycle).
  - pc <= redirect_pc; state <= RUN.
  - Any pop in the same cycle is ignored.
- Redirect while inflight:
  - Flush the queue and latch redirect_pc.
  - Set discard. rd_cmd and addr stay on the old fetch.
  - On completion, the data and any fault are dropped and pc <= latched target.
  - If completion happens in the same cycle as the redirect, the data is dropped and pc <= redirect_pc directly.
  - A later redirect before completion overwrites the latched target.
- A faulted entry is delivered to decode like a normal entry. The stage stays in HALT after the fault entry is popped.
- Reset asserted mid-fetch:
  - Everything returns to reset values and rd_cmd drops immediately.
  - The IFU's own reset is shared.

Decomposition:
- cpu_const.vh: exception codes FETCH_EXC_NONE/ALIGN/BUS and the default reset vector.
- cpu_common.vh: width macros.
- One sub-module, fetch_queue: 2-entry FIFO of {pc, instr, exc} with push, pop, flush and count.

Test Plan:
1. RESET_ADDR=0x100, busy=0, i_ready=1 -> addr 0x100, 0x104, 0x108 on consecutive cycles; o_valid from cycle 2 with o_pc 0x100, 0x104, and o_instr matching.
2. busy=1 for 3 cycles on fetch at 0x100 -> rd_cmd/addr held at 0x100 for 4 cycles; exactly one push; next addr 0x104.
3. i_ready=0 -> after 2 pushes rd_cmd=0 with count=2; raise i_ready -> entries 0x100 and 0x104 popped in order, fetch of 0x108 resumes.
4. redirect to 0x200 during busy on 0x104 -> addr held at 0x104 until completion; 0x104 data never appears on o_valid; next addr 0x200; first o_pc 0x200.
5. redirect to 0x202 -> err_align -> entry o_pc=0x202, o_exc=1, rd_cmd stays 0; redirect to 0x300 -> fetch resumes at 0x300.
6. err_bus on 0x400 -> o_exc=2, HALT. In a second run, rst during a 5-cycle wait -> rd_cmd=0 immediately, o_valid=0, first addr after release = RESET_ADDR.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: exception codes, FSM
// states, default widths and reset vector.
package fetch_stage_pkg;

  localparam int          CPU_ADDR_WIDTH   = 32;
  localparam int          CPU_INSTR_WIDTH  = 32;
  localparam logic [31:0] CPU_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_EXC_NONE  = 2'd0,
    FETCH_EXC_ALIGN = 2'd1,
    FETCH_EXC_BUS   = 2'd2
  } fetch_exc_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Alignment faults win over bus faults when both are reported together.
  function automatic fetch_exc_e fetch_exc_code(input logic align, input logic bus);
    if (align)    return FETCH_EXC_ALIGN;
    else if (bus) return FETCH_EXC_BUS;
    else          return FETCH_EXC_NONE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-IFU command/response bundle. The fetch stage is the master.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   rd_cmd;
  logic [INSTR_WIDTH-1:0] instr_dat;
  logic                   busy;
  logic                   err_align;
  logic                   err_bus;

  modport master (
    output addr, rd_cmd,
    input  instr_dat, busy, err_align, err_bus
  );

  modport slave (
    input  addr, rd_cmd,
    output instr_dat, busy, err_align, err_bus
  );
endinterface

// File: rtl/fetch_stage_queue.sv
// Two-entry FIFO of {pc, instr, exc} towards decode. Slot 0 is always the
// head, so the decode-facing outputs come straight from registers.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  input  fetch_exc_e             push_exc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [1:0]             count,
  output logic                   head_valid,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output fetch_exc_e             head_exc
);

  logic [ADDR_WIDTH-1:0]  pc0, pc1;
  logic [INSTR_WIDTH-1:0] instr0, instr1;
  fetch_exc_e             exc0, exc1;
  logic                   do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_pc    = pc0;
  assign head_instr = instr0;
  assign head_exc   = exc0;

  // Shift-register FIFO: pops move slot 1 forward, pushes land behind the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      pc0    <= '0;
      pc1    <= '0;
      instr0 <= '0;
      instr1 <= '0;
      exc0   <= FETCH_EXC_NONE;
      exc1   <= FETCH_EXC_NONE;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
            exc0   <= push_exc;
          end else begin
            pc1    <= push_pc;
            instr1 <= push_instr;
            exc1   <= push_exc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0    <= pc1;
          instr0 <= instr1;
          exc0   <= exc1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
            exc0   <= push_exc;
          end else begin
            pc0    <= pc1;
            instr0 <= instr1;
            exc0   <= exc1;
            pc1    <= push_pc;
            instr1 <= push_instr;
            exc1   <= push_exc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, drives the IFU read command, queues fetched
// instructions (or faults) for decode and handles redirects.
//
// state   | meaning
// ST_RUN  | issuing fetches whenever the queue has room
// ST_HALT | a fault entry has been queued; no issue until a redirect
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = CPU_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = CPU_RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_stage_if.master          ifu,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [1:0]             o_exc,
  input  logic                   i_ready
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  tgt_q, tgt_d;
  logic                   inflight_q, inflight_d;
  logic                   discard_q, discard_d;
  logic [1:0]             q_count;
  logic                   done, fault, pop;
  logic                   push;
  logic [INSTR_WIDTH-1:0] push_instr;
  fetch_exc_e             push_exc;
  fetch_exc_e             head_exc;

  // An outstanding fetch keeps rd_cmd high; a new issue needs room and no redirect.
  assign ifu.rd_cmd = !rst && (inflight_q ||
                      (state_q == ST_RUN && q_count != 2'd2 && !redirect));
  assign ifu.addr   = pc_q;
  assign done       = ifu.rd_cmd && !ifu.busy;
  assign fault      = ifu.err_align || ifu.err_bus;
  assign pop        = o_valid && i_ready && !redirect;
  assign o_exc      = head_exc;

  // Registered fetch state: PC, FSM state, outstanding-fetch and discard tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_ADDR;
      tgt_q      <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Next-state and queue-push decisions for redirects and fetch completion.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    push       = 1'b0;
    push_instr = '0;
    push_exc   = FETCH_EXC_NONE;
    if (redirect) begin
      state_d = ST_RUN;
      if (!inflight_q || done) begin
        // Nothing pending, or the pending fetch finishes now and is dropped.
        pc_d       = redirect_pc;
        inflight_d = 1'b0;
        discard_d  = 1'b0;
      end else begin
        tgt_d     = redirect_pc;
        discard_d = 1'b1;
      end
    end else if (done) begin
      inflight_d = 1'b0;
      if (discard_q) begin
        pc_d      = tgt_q;
        discard_d = 1'b0;
      end else if (fault) begin
        push     = 1'b1;
        push_exc = fetch_exc_code(ifu.err_align, ifu.err_bus);
        state_d  = ST_HALT;
      end else begin
        push       = 1'b1;
        push_instr = ifu.instr_dat;
        pc_d       = pc_q + ADDR_WIDTH'(4);
      end
    end else if (ifu.rd_cmd) begin
      inflight_d = 1'b1;
    end
  end

  fetch_queue #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (push_instr),
    .push_exc   (push_exc),
    .pop        (pop),
    .flush      (redirect),
    .count      (q_count),
    .head_valid (o_valid),
    .head_pc    (o_pc),
    .head_instr (o_instr),
    .head_exc   (head_exc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [1:0]  o_exc;

  fetch_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) ifu ();

  fetch_stage #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_ADDR  (RST_VEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu         (ifu),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_exc       (o_exc),
    .i_ready     (i_ready)
  );

  always #5 clk = ~clk;

  // IFU behaviour: memory content is a fixed function of the address,
  // misaligned addresses fault, and the 0x400-0x4FF page is a bus-fault page.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  function automatic logic in_bus_region(input logic [31:0] a);
    return (a[31:8] == 24'h000004);
  endfunction

  assign ifu.instr_dat = mem_word(ifu.addr);
  assign ifu.err_align = ifu.rd_cmd && (ifu.addr[1:0] != 2'b00);
  assign ifu.err_bus   = ifu.rd_cmd && in_bus_region(ifu.addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural PC, halted flag, one outstanding fetch
  // with optional pending redirect target, and an ordered list of entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  exc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_halt;
  logic        m_pend;
  logic        m_disc;

  task automatic model_reset();
    m_pc   = RST_VEC;
    m_tgt  = '0;
    m_halt = 1'b0;
    m_pend = 1'b0;
    m_disc = 1'b0;
    m_q.delete();
  endtask

  // Compare this cycle's outputs to the model, then advance the model by one clock.
  task automatic check_and_advance();
    logic       exp_rd;
    logic       fin;
    logic [1:0] code;
    ent_t       e;
    exp_rd = !rst && (m_pend || (!m_halt && m_q.size() < 2 && !redirect));
    check("rd_cmd", 32'(ifu.rd_cmd), 32'(exp_rd));
    if (exp_rd) check("addr", ifu.addr, m_pc);
    check("o_valid", 32'(o_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("o_pc", o_pc, m_q[0].pc);
      check("o_instr", o_instr, m_q[0].instr);
      check("o_exc", 32'(o_exc), 32'(m_q[0].exc));
    end
    if (rst) begin
      model_reset();
      return;
    end
    fin  = exp_rd && !ifu.busy;
    code = (m_pc[1:0] != 2'b00) ? 2'd1 : (in_bus_region(m_pc) ? 2'd2 : 2'd0);
    if (!redirect && m_q.size() != 0 && i_ready) void'(m_q.pop_front());
    if (redirect) begin
      m_q.delete();
      m_halt = 1'b0;
      if (!m_pend || fin) begin
        m_pc   = redirect_pc;
        m_pend = 1'b0;
        m_disc = 1'b0;
      end else begin
        m_tgt  = redirect_pc;
        m_disc = 1'b1;
      end
    end else if (fin) begin
      m_pend = 1'b0;
      if (m_disc) begin
        m_pc   = m_tgt;
        m_disc = 1'b0;
      end else if (code != 2'd0) begin
        e.pc = m_pc; e.instr = '0; e.exc = code;
        m_q.push_back(e);
        m_halt = 1'b1;
      end else begin
        e.pc = m_pc; e.instr = mem_word(m_pc); e.exc = 2'd0;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end else if (exp_rd) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic step(input logic b, input logic rdy, input logic rd, input logic [31:0] tgt);
    ifu.busy    = b;
    i_ready     = rdy;
    redirect    = rd;
    redirect_pc = tgt;
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0200;
      1:       return 32'h0000_0202;
      2:       return 32'h0000_0300;
      3:       return 32'h0000_0400 + 32'($urandom_range(0, 3)) * 4;
      4:       return 32'hFFFF_FFF8;
      default: return 32'h0000_0800 + 32'($urandom_range(0, 63)) * 4;
    endcase
  endfunction

  task automatic rand_cycles(input int n, input int busy_pct, input int rdy_pct, input int redir_pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < busy_pct,
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 99) < redir_pct,
           pick_target());
    end
  endtask

  initial begin
    rst         = 1'b1;
    ifu.busy    = 1'b0;
    i_ready     = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rd_cmd", 32'(ifu.rd_cmd), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_pc", o_pc, 32'd0);
    check("rst_o_instr", o_instr, 32'd0);
    check("rst_o_exc", 32'(o_exc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("first_addr", ifu.addr, RST_VEC);

    // Zero-wait streaming with decode always ready.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Hold a fetch in a wait state, then reset in the middle of it.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0);
    rst = 1'b0;
    #1;
    check("rst_mid_o_valid", 32'(o_valid), 32'd0);
    check("rst_mid_addr", ifu.addr, RST_VEC);

    // Backpressure only: queue fills, fetch stalls, then drains in order.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Redirect to a misaligned target, then recover with a clean redirect.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0202);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

    rand_cycles(250, 50, 100, 4);
    rand_cycles(250, 30, 25, 4);
    rand_cycles(300, 40, 60, 12);
    rand_cycles(200, 70, 50, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
